ula_arbiter: RTL
================

Name: ula_arbiter

Overview:
- Shares one instance of the existing combinational `ula` between two requesters (port 0, port 1).
- Each port issues an op code plus two operands over a valid/ready request channel and receives a registered result over a valid/ready response channel.
- Requesters are arbitrated round-robin, one operation is in flight at a time, and per-port completed-operation counters are kept.
- Sits between the requesting datapath units (e.g. address generation and execute stage) and the ALU.

Parameters:
- CNT_W, 16, width of each per-port completed-operation counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_f  in  4  port 0 ALU op code.
- req0_a  in  32  port 0 operand A.
- req0_b  in  32  port 0 operand B.
- resp0_valid  out  1  port 0 result valid.
- resp0_ready  in  1  port 0 result consumed.
- resp0_data  out  32  port 0 result.
- resp0_zero  out  1  port 0 result equals 0.
- req1_valid, req1_ready, req1_f, req1_a, req1_b  (as port 0)  port 1 request channel.
- resp1_valid, resp1_ready, resp1_data, resp1_zero  (as port 0)  port 1 response channel.
- busy  out  1  high whenever state is not IDLE.
- cnt0  out  CNT_W  completed ops on port 0.
- cnt1  out  CNT_W  completed ops on port 1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=1, so port 0 wins the first tie; operand/op/result registers cleared; all resp*_valid=0, resp*_data=0, resp*_zero=0, busy=0, cnt0=cnt1=0, req*_ready=0. Reset asserted mid-operation aborts the operation; no response is issued.
- Operation latency: request accepted at edge T, result registered at edge T+1, respN_valid high from T+2.
- ULA op codes:
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 XNOR, 1110 NOT A, 1111 NOT B, 1010 pass A.
  - Any other code yields 0.
  - 32-bit arithmetic, wrap-around; no carry or overflow output.
- State IDLE:
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port != last_grant.
  - reqN_ready is combinationally high only for the granted port, and only in IDLE.
  - On the accepting edge: latch f/a/b and the grant id into `owner`, set last_grant=owner, go to EXEC.
  - No valid requests: stay in IDLE.
- State EXEC: the ULA is driven from the latched registers. On the next edge, register the result into resp_data, set zero=(result==0), and go to RESP.
- State RESP:
  - resp{owner}_valid=1 with data/zero held stable. The other port's resp_valid stays 0.
  - When resp{owner}_ready=1 at an edge: cnt{owner} increments, valid drops, and state returns to IDLE.
  - Otherwise hold indefinitely (backpressure); no new request is accepted.
- Throughput: at most one operation per 3 cycles. A request arriving during EXEC/RESP waits, with reqN_ready=0. Requesters must hold valid and payload stable until ready.
- resp_data/resp_zero keep their last value after the handshake; only valid drops.
- reqN_valid must not depend combinationally on reqN_ready. The block guarantees that reqN_ready does not depend on respN_ready.
- Counter at all-ones increments to 0.
- busy = (state != IDLE).

Test Plan:
- After reset, req0 ADD (f=0010) a=5 b=7, resp0_ready=1: req0_ready pulses 1 cycle; resp0_valid at T+2 with data=12, zero=0; cnt0=1; busy high for 2 cycles.
- req1 SUB a=3 b=5 -> resp1_data=0xFFFFFFFE. Then SUB a=9 b=9 -> data=0, zero=1. Then f=0101 -> data=0, zero=1. Then NOT B with b=0 -> 0xFFFFFFFF.
- Both ports request continuously from reset:
  - Grants alternate 0,1,0,1.
  - Port 0 OR a=0xF0 b=0x0F -> 0xFF; port 1 XNOR a=b=0x1234 -> 0xFFFFFFFF.
  - resp1_valid never high while owner=0.
  - cnt0=cnt1=2 after 4 ops.
- Backpressure: resp0_ready=0 for 10 cycles:
  - resp0_valid and data stay stable.
  - A pending req1 sees req1_ready=0 throughout.
  - On release, port 1 is granted on the next IDLE cycle.
- Assert rst_n=0 asynchronously during EXEC: all outputs reach their reset values immediately; no response follows; the next op after release on both ports goes to port 0.
- With CNT_W=2, complete 5 port-0 ops: cnt0 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// One operation in flight; result is registered and held until its owner consumes it.
module ula_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_f,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_data,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_f,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_data,
  output logic             resp1_zero,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // state | meaning
  // IDLE  | waiting for a request; grants one port
  // EXEC  | ULA driven from latched operands
  // RESP  | result held for the owning port until consumed
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic [3:0]       f_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [31:0]      result;
  logic [31:0]      data_r;
  logic             zero_r;
  logic             v0_r;
  logic             v1_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  function automatic logic [31:0] ula(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    case (f)
      4'b0010: y = a + b;
      4'b0110: y = a - b;
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b1100: y = ~(a ^ b);
      4'b1110: y = ~a;
      4'b1111: y = ~b;
      4'b1010: y = a;
      default: y = '0;
    endcase
    return y;
  endfunction

  assign result = ula(f_r, a_r, b_r);

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  // Gated by rst_n so ready reads low while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      f_r        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      data_r     <= '0;
      zero_r     <= 1'b0;
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      busy_r     <= 1'b0;
      cnt0_r     <= '0;
      cnt1_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner      <= grant;
            last_grant <= grant;
            f_r        <= grant ? req1_f : req0_f;
            a_r        <= grant ? req1_a : req0_a;
            b_r        <= grant ? req1_b : req0_b;
            busy_r     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          data_r <= result;
          zero_r <= (result == '0);
          v0_r   <= !owner;
          v1_r   <= owner;
          state  <= RESP;
        end
        RESP: begin
          if ((!owner && resp0_ready) || (owner && resp1_ready)) begin
            if (owner) cnt1_r <= cnt1_r + CNT_W'(1);
            else       cnt0_r <= cnt0_r + CNT_W'(1);
            v0_r   <= 1'b0;
            v1_r   <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp0_valid = v0_r;
  assign resp1_valid = v1_r;
  assign resp0_data  = data_r;
  assign resp1_data  = data_r;
  assign resp0_zero  = zero_r;
  assign resp1_zero  = zero_r;
  assign busy        = busy_r;
  assign cnt0        = cnt0_r;
  assign cnt1        = cnt1_r;

endmodule
